// File: rtl/theta_iterative_engine.sv
// Multi-cycle Keccak theta step: column parities over 5 cycles, then the
// theta correction applied one plane per cycle over 5 more cycles.
module theta_iterative_engine #(
    parameter int LANE_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [25*LANE_W-1:0]  in_state,
    input  logic                  theta_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [25*LANE_W-1:0]  out_state,
    output logic [5*LANE_W-1:0]   parity,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PARITY,
        S_APPLY,
        S_DONE
    } fsm_t;

    fsm_t              fsm_reg;
    logic [2:0]        plane_reg;
    logic              theta_en_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              busy_reg;

    // Lanes are held as [y][x] so the plane counter selects a whole row directly.
    logic [LANE_W-1:0] lane_reg [5][5];
    logic [LANE_W-1:0] in_lane  [5][5];
    logic [LANE_W-1:0] c_reg    [5];
    logic [LANE_W-1:0] rot_c    [5];
    logic [LANE_W-1:0] d        [5];

    genvar gi, gj;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_plane
            for (gj = 0; gj < 5; gj++) begin : g_lane
                assign in_lane[gi][gj] = in_state[(5*gi+gj)*LANE_W +: LANE_W];
                assign out_state[(5*gi+gj)*LANE_W +: LANE_W] = lane_reg[gi][gj];
            end
        end

        for (gi = 0; gi < 5; gi++) begin : g_col
            // Rotation by one toward higher z; a 1-bit lane has nothing to rotate.
            if (LANE_W == 1) begin : g_rot1
                assign rot_c[gi] = c_reg[gi];
            end else begin : g_rotn
                assign rot_c[gi] = {c_reg[gi][LANE_W-2:0], c_reg[gi][LANE_W-1]};
            end
            assign d[gi] = c_reg[(gi+4)%5] ^ rot_c[(gi+1)%5];
            assign parity[gi*LANE_W +: LANE_W] = c_reg[gi];
        end
    endgenerate

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg       <= S_IDLE;
            plane_reg     <= 3'd0;
            theta_en_reg  <= 1'b1;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            lane_reg      <= '{default: '0};
            c_reg         <= '{default: '0};
        end else begin
            case (fsm_reg)
                S_IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        lane_reg     <= in_lane;
                        theta_en_reg <= theta_en;
                        c_reg        <= '{default: '0};
                        plane_reg    <= 3'd0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        fsm_reg      <= S_PARITY;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end

                S_PARITY: begin
                    for (int x = 0; x < 5; x++) begin
                        c_reg[x] <= c_reg[x] ^ lane_reg[plane_reg][x];
                    end
                    if (plane_reg == 3'd4) begin
                        plane_reg <= 3'd0;
                        fsm_reg   <= S_APPLY;
                    end else begin
                        plane_reg <= plane_reg + 3'd1;
                    end
                end

                S_APPLY: begin
                    // Pass-through still walks all five planes to keep latency fixed.
                    if (theta_en_reg) begin
                        for (int x = 0; x < 5; x++) begin
                            lane_reg[plane_reg][x] <= lane_reg[plane_reg][x] ^ d[x];
                        end
                    end
                    if (plane_reg == 3'd4) begin
                        plane_reg     <= 3'd0;
                        out_valid_reg <= 1'b1;
                        fsm_reg       <= S_DONE;
                    end else begin
                        plane_reg <= plane_reg + 3'd1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        fsm_reg       <= S_IDLE;
                    end
                end

                default: begin
                    fsm_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_theta_iterative_engine.sv
// Directed bench for theta_iterative_engine at LANE_W=64 and LANE_W=1 with a
// reference theta model feeding an expected-result queue.
module tb_theta_iterative_engine;

    typedef struct {
        logic [1599:0] st;
        logic [319:0]  par;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid, in_ready, theta_en, out_valid, out_ready, busy;
    logic [1599:0] in_state, out_state;
    logic [319:0]  parity;

    logic          in_valid1, in_ready1, theta_en1, out_valid1, out_ready1, busy1;
    logic [24:0]   in_state1, out_state1;
    logic [4:0]    parity1;

    exp_t        sb[$];
    logic [24:0] sb1[$];
    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;

    theta_iterative_engine #(.LANE_W(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .theta_en(theta_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .parity(parity), .busy(busy)
    );

    theta_iterative_engine #(.LANE_W(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_state(in_state1), .theta_en(theta_en1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_state(out_state1),
        .parity(parity1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        int lane;
        total++;
        assert (obs === exp) else begin
            bad++;
            lane = 0;
            for (int i = 24; i >= 0; i--)
                if (obs[i*64 +: 64] !== exp[i*64 +: 64]) lane = i;
            $error("FAIL %s lane=%0d observed=%h expected=%h", tag, lane,
                   obs[lane*64 +: 64], exp[lane*64 +: 64]);
        end
    endtask

    function automatic logic [319:0] par_of(input logic [1599:0] s);
        logic [319:0] p;
        p = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                p[x*64 +: 64] = p[x*64 +: 64] ^ s[(5*y+x)*64 +: 64];
        return p;
    endfunction

    function automatic logic [1599:0] theta_of(input logic [1599:0] s, input logic en);
        logic [319:0]  c;
        logic [1599:0] o;
        logic          dz;
        c = par_of(s);
        o = s;
        if (en) begin
            for (int x = 0; x < 5; x++)
                for (int z = 0; z < 64; z++) begin
                    dz = c[((x+4)%5)*64 + z] ^ c[((x+1)%5)*64 + ((z+63)%64)];
                    for (int y = 0; y < 5; y++)
                        o[(5*y+x)*64 + z] = o[(5*y+x)*64 + z] ^ dz;
                end
        end
        return o;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send64(input logic [1599:0] st, input logic en,
                          input logic [1599:0] es, input logic [319:0] ep);
        int   n = 0;
        exp_t e;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 320'(in_ready), 320'(1));
        in_valid = 1'b1;
        in_state = st;
        theta_en = en;
        e.st  = es;
        e.par = ep;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_state = '0;
    endtask

    task automatic recv64(input int hold, input string name);
        int   n = 0;
        exp_t e;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        txn++;
        $display("txn %0d %s: latency=%0d hold=%0d", txn, name, n, hold);
        chk("latency", 320'(n), 320'(10));
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.st  = '0;
            e.par = '0;
        end
        chk_state("out_state", out_state, e.st);
        chk("parity", parity, e.par);
        chk("busy_done", 320'(busy), 320'(1));
        chk("in_ready_done", 320'(in_ready), 320'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 320'(out_valid), 320'(1));
            chk_state("bp_out_state", out_state, e.st);
            chk("bp_parity", parity, e.par);
            chk("bp_in_ready", 320'(in_ready), 320'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_in_ready", 320'(in_ready), 320'(1));
        chk("post_out_valid", 320'(out_valid), 320'(0));
        chk("post_busy", 320'(busy), 320'(0));
    endtask

    initial begin
        logic [1599:0] st, es, r;
        logic [24:0]   e1, x1;
        int            n;

        rst = 1'b1;
        in_valid = 1'b0; in_state = '0; theta_en = 1'b1; out_ready = 1'b0;
        in_valid1 = 1'b0; in_state1 = '0; theta_en1 = 1'b1; out_ready1 = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready", 320'(in_ready), 320'(0));
        chk("rst_out_valid", 320'(out_valid), 320'(0));
        chk("rst_busy", 320'(busy), 320'(0));
        chk_state("rst_out_state", out_state, '0);
        chk("rst_parity", parity, '0);
        chk("rst_in_ready_w1", 320'(in_ready1), 320'(0));

        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 320'(in_ready), 320'(1));

        // All-zero state
        send64('0, 1'b1, '0, '0);
        recv64(0, "zero");

        // Single bit in lane(0,0)
        st = '0;
        st[0] = 1'b1;
        es = '0;
        es[0 +: 64] = 64'h1;
        for (int y = 0; y < 5; y++) begin
            es[(5*y+1)*64 +: 64] = 64'h1;
            es[(5*y+4)*64 +: 64] = 64'h2;
        end
        send64(st, 1'b1, es, 320'h1);
        recv64(0, "single_bit");

        // LANE_W=1, lane(2,3) set; out_ready held high well before DONE
        e1 = '0;
        for (int y = 0; y < 5; y++) begin
            e1[5*y+1] = 1'b1;
            e1[5*y+3] = 1'b1;
        end
        e1[17] = 1'b1;
        sb1.push_back(e1);
        n = 0;
        while (in_ready1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid1  = 1'b1;
        in_state1  = 25'd1 << 17;
        theta_en1  = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        n = 0;
        while (out_valid1 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        txn++;
        $display("txn %0d lane_w1: latency=%0d", txn, n);
        x1 = sb1.pop_front();
        chk("w1_latency", 320'(n), 320'(10));
        chk("w1_out_state", 320'(out_state1), 320'(x1));
        chk("w1_parity", 320'(parity1), 320'(5'b00100));
        @(negedge clk);
        chk("w1_out_valid_drop", 320'(out_valid1), 320'(0));
        chk("w1_in_ready_back", 320'(in_ready1), 320'(1));
        out_ready1 = 1'b0;

        // Pass-through of a random state
        r = rand_state();
        send64(r, 1'b0, r, par_of(r));
        recv64(0, "passthru");

        // Backpressure for 6 cycles, then a second state
        r = rand_state();
        send64(r, 1'b1, theta_of(r, 1'b1), par_of(r));
        recv64(6, "backpressure");
        r = rand_state();
        send64(r, 1'b1, theta_of(r, 1'b1), par_of(r));
        recv64(0, "after_bp");

        // Reset asserted across E8 (APPLY)
        r = rand_state();
        send64(r, 1'b1, theta_of(r, 1'b1), par_of(r));
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_state("abort_out_state", out_state, '0);
        chk("abort_parity", parity, '0);
        chk("abort_out_valid", 320'(out_valid), 320'(0));
        chk("abort_in_ready", 320'(in_ready), 320'(0));
        chk("abort_busy", 320'(busy), 320'(0));
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("abort_in_ready_back", 320'(in_ready), 320'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_out_valid", 320'(out_valid), 320'(0));
        end
        txn++;
        $display("txn %0d aborted by reset", txn);

        r = rand_state();
        send64(r, 1'b1, theta_of(r, 1'b1), par_of(r));
        recv64(0, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
